// File: rtl/bcd_timer_chain.sv
// Cascaded BCD stopwatch/countdown core: tenths, seconds LSD/MSD and MIN_DIGITS minute digits.
// Define TIMER_LAP_EN to add the lap-capture input, lap registers and lap_valid.
module bcd_timer_chain #(
    parameter int MIN_DIGITS = 1
) (
    input  logic                    tick,
    input  logic                    clr,
    input  logic                    enable,
    input  logic                    dswitch,
    input  logic                    stop_mode,
    input  logic                    load,
    input  logic [4*MIN_DIGITS-1:0] load_min,
    input  logic [3:0]              load_sec_msd,
    input  logic [3:0]              load_sec_lsd,
    input  logic [3:0]              load_tenth,
`ifdef TIMER_LAP_EN
    input  logic                    lap,
    output logic [4*MIN_DIGITS-1:0] lap_min,
    output logic [3:0]              lap_sec_msd,
    output logic [3:0]              lap_sec_lsd,
    output logic [3:0]              lap_tenth,
    output logic                    lap_valid,
`endif
    output logic [4*MIN_DIGITS-1:0] min,
    output logic [3:0]              sec_msd,
    output logic [3:0]              sec_lsd,
    output logic [3:0]              tenth,
    output logic                    wrap,
    output logic                    expired
);

    // Digit 0 is tenths, 1 seconds LSD, 2 seconds MSD, 3.. minutes (least significant first).
    localparam int N = MIN_DIGITS + 3;

    logic [3:0] digit   [N];
    logic [3:0] preset  [N];
    logic [3:0] counted [N];
    logic       at_term;
    logic       next_term;

    function automatic logic [3:0] max_of(input int idx);
        return (idx == 2) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_comb begin
        preset[0] = clamp(load_tenth, 4'd9);
        preset[1] = clamp(load_sec_lsd, 4'd9);
        preset[2] = clamp(load_sec_msd, 4'd5);
        for (int i = 0; i < MIN_DIGITS; i++) begin
            preset[3+i] = clamp(load_min[4*i +: 4], 4'd9);
        end
    end

    // Ripple carry/borrow through the whole chain in one cycle. A carry out of the
    // top digit happens exactly when every digit sits at the terminal value.
    always_comb begin
        logic carry;
        // NOTE: every always_comb output gets a default before any conditional
        // assignment, otherwise a path that skips it infers a latch.
        carry     = 1'b1;
        at_term   = 1'b1;
        next_term = 1'b1;
        for (int i = 0; i < N; i++) begin
            counted[i] = digit[i];
            if (carry) begin
                if (dswitch) begin
                    counted[i] = (digit[i] == max_of(i)) ? 4'd0 : digit[i] + 4'd1;
                    carry      = (digit[i] == max_of(i));
                end else begin
                    counted[i] = (digit[i] == 4'd0) ? max_of(i) : digit[i] - 4'd1;
                    carry      = (digit[i] == 4'd0);
                end
            end
            at_term   = at_term   & (dswitch ? (digit[i]   == max_of(i)) : (digit[i]   == 4'd0));
            next_term = next_term & (dswitch ? (counted[i] == max_of(i)) : (counted[i] == 4'd0));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge tick or posedge clr) begin
        if (clr) begin
            // NOTE: the digit array is a handful of flops, not a RAM, so it is reset
            // like any other register.
            digit   <= '{default: 4'd0};
            wrap    <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            digit   <= preset;
            wrap    <= 1'b0;
            expired <= 1'b0;
        end else if (enable && !expired) begin
            if (stop_mode) begin
                wrap <= 1'b0;
                if (at_term) begin
                    expired <= 1'b1;
                end else begin
                    digit   <= counted;
                    expired <= next_term;
                end
            end else begin
                digit <= counted;
                wrap  <= at_term;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign tenth   = digit[0];
    assign sec_lsd = digit[1];
    assign sec_msd = digit[2];

    for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
        assign min[4*g +: 4] = digit[3+g];
    end

`ifdef TIMER_LAP_EN
    // Captures the value shown before the edge, so a coincident load or step is not seen.
    always_ff @(posedge tick or posedge clr) begin
        if (clr) begin
            lap_min     <= '0;
            lap_sec_msd <= 4'd0;
            lap_sec_lsd <= 4'd0;
            lap_tenth   <= 4'd0;
            lap_valid   <= 1'b0;
        end else if (lap) begin
            for (int i = 0; i < MIN_DIGITS; i++) begin
                lap_min[4*i +: 4] <= digit[3+i];
            end
            lap_sec_msd <= digit[2];
            lap_sec_lsd <= digit[1];
            lap_tenth   <= digit[0];
            lap_valid   <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Scoreboard bench for bcd_timer_chain (MIN_DIGITS=2): the driver queues hand-computed
// expectations, a monitor pops one per clock edge and compares.
module tb_bcd_timer_chain;

    localparam int          MD    = 2;
    localparam logic [21:0] ALL   = 22'h3F_FFFF;
    localparam logic [21:0] FLAGS = 22'h00_0003;

    logic          tick = 1'b0;
    logic          clr = 1'b0;
    logic          enable = 1'b0;
    logic          dswitch = 1'b1;
    logic          stop_mode = 1'b0;
    logic          load = 1'b0;
    logic [4*MD-1:0] load_min = '0;
    logic [3:0]    load_sec_msd = 4'd0;
    logic [3:0]    load_sec_lsd = 4'd0;
    logic [3:0]    load_tenth = 4'd0;
    logic [4*MD-1:0] min;
    logic [3:0]    sec_msd;
    logic [3:0]    sec_lsd;
    logic [3:0]    tenth;
    logic          wrap;
    logic          expired;
`ifdef TIMER_LAP_EN
    logic          lap = 1'b0;
    logic [4*MD-1:0] lap_min;
    logic [3:0]    lap_sec_msd;
    logic [3:0]    lap_sec_lsd;
    logic [3:0]    lap_tenth;
    logic          lap_valid;
`endif

    bcd_timer_chain #(.MIN_DIGITS(MD)) dut (
        .tick(tick), .clr(clr), .enable(enable), .dswitch(dswitch),
        .stop_mode(stop_mode), .load(load), .load_min(load_min),
        .load_sec_msd(load_sec_msd), .load_sec_lsd(load_sec_lsd), .load_tenth(load_tenth),
`ifdef TIMER_LAP_EN
        .lap(lap), .lap_min(lap_min), .lap_sec_msd(lap_sec_msd),
        .lap_sec_lsd(lap_sec_lsd), .lap_tenth(lap_tenth), .lap_valid(lap_valid),
`endif
        .min(min), .sec_msd(sec_msd), .sec_lsd(sec_lsd), .tenth(tenth),
        .wrap(wrap), .expired(expired)
    );

    always #5 tick = ~tick;

    typedef struct {
        logic [21:0] exp;
        logic [21:0] mask;
        string       name;
    } sb_t;

    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic [21:0] obs;

    assign obs = {min, sec_msd, sec_lsd, tenth, wrap, expired};

    function automatic logic [21:0] pk(input logic [7:0] m, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c,
                                       input logic w, input logic e);
        return {m, a, b, c, w, e};
    endfunction

    task automatic check(input string nm, input logic [21:0] got,
                         input logic [21:0] exp, input logic [21:0] mask);
        n_checks++;
        if ((got & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got {min,msd,lsd,tenth,wrap,exp}=%h_%h_%h_%h_%b_%b expected %h_%h_%h_%h_%b_%b (mask %h)",
                     nm, got[21:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                     exp[21:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0], mask);
        end
    endtask

    task automatic step(input bit en, input bit up, input bit stp,
                        input logic [21:0] e, input logic [21:0] m, input string nm);
        @(negedge tick);
        load      = 1'b0;
        enable    = en;
        dswitch   = up;
        stop_mode = stp;
        sb.push_back('{exp: e, mask: m, name: nm});
    endtask

    task automatic ld_step(input logic [7:0] lm, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input bit en, input bit up, input bit stp,
                           input logic [21:0] e, input string nm);
        @(negedge tick);
        load         = 1'b1;
        load_min     = lm;
        load_sec_msd = a;
        load_sec_lsd = b;
        load_tenth   = c;
        enable       = en;
        dswitch      = up;
        stop_mode    = stp;
        sb.push_back('{exp: e, mask: ALL, name: nm});
    endtask

    task automatic drain();
        @(negedge tick);
        enable = 1'b0;
        load   = 1'b0;
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            @(posedge tick);
            #2;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never consumed, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    initial begin
        sb_t e;
        forever begin
            @(posedge tick);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, obs, e.exp, e.mask);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 clr = 1'b1;
        #2 check("reset_state", obs, '0, ALL);
        repeat (2) @(negedge tick);
        clr = 1'b0;

        // 600 up ticks from zero: one minute, never wrapping.
        for (int k = 1; k <= 600; k++) begin
            logic [21:0] e;
            logic [21:0] m;
            e = '0;
            m = FLAGS;
            if (k == 1)        begin e = pk(8'h00, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0); m = ALL; end
            else if (k == 10)  begin e = pk(8'h00, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0); m = ALL; end
            else if (k == 599) begin e = pk(8'h00, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0); m = ALL; end
            else if (k == 600) begin e = pk(8'h01, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0); m = ALL; end
            step(1'b1, 1'b1, 1'b0, e, m, "count_up_minute");
        end

        // Load wins over a coincident enable; then up-wrap with a one-cycle pulse.
        ld_step(8'h99, 4'd5, 4'd9, 4'd8, 1'b1, 1'b1, 1'b0, pk(8'h99, 4'd5, 4'd9, 4'd8, 1'b0, 1'b0), "load_with_enable");
        step(1'b1, 1'b1, 1'b0, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0), ALL, "up_to_max");
        step(1'b1, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0), ALL, "up_wrap");
        step(1'b0, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0), ALL, "wrap_one_cycle");

        // Down-wrap from zero.
        step(1'b1, 1'b0, 1'b0, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b1, 1'b0), ALL, "down_wrap");
        step(1'b0, 1'b0, 1'b0, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0), ALL, "down_wrap_hold");

        // Countdown in stop mode from 00:01.0.
        ld_step(8'h00, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1, pk(8'h00, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0), "load_countdown");
        for (int k = 1; k <= 15; k++) begin
            logic [21:0] e;
            if (k < 10) e = pk(8'h00, 4'd0, 4'd0, 4'(10 - k), 1'b0, 1'b0);
            else        e = pk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b1, e, ALL, "countdown_stop");
        end
        step(1'b1, 1'b1, 1'b1, pk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1), ALL, "expired_dir_flip");
        step(1'b1, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1), ALL, "expired_mode_flip");
        ld_step(8'h00, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1, pk(8'h00, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0), "load_clears_expired");
        step(1'b1, 1'b0, 1'b1, pk(8'h00, 4'd0, 4'd4, 4'd9, 1'b0, 1'b0), ALL, "resume_after_load");

        // Stop mode counting up reaches all-max and halts.
        ld_step(8'h99, 4'd5, 4'd9, 4'd7, 1'b0, 1'b1, 1'b1, pk(8'h99, 4'd5, 4'd9, 4'd7, 1'b0, 1'b0), "load_up_stop");
        step(1'b1, 1'b1, 1'b1, pk(8'h99, 4'd5, 4'd9, 4'd8, 1'b0, 1'b0), ALL, "up_stop_step");
        step(1'b1, 1'b1, 1'b1, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b0, 1'b1), ALL, "up_stop_reach");
        step(1'b1, 1'b1, 1'b1, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b0, 1'b1), ALL, "up_stop_hold");

        // Out-of-range presets clamp per digit.
        ld_step(8'hCC, 4'h7, 4'hA, 4'hF, 1'b0, 1'b1, 1'b0, pk(8'h99, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0), "clamp_all");
        ld_step(8'hC3, 4'h6, 4'h5, 4'h9, 1'b0, 1'b1, 1'b0, pk(8'h93, 4'd5, 4'd5, 4'd9, 1'b0, 1'b0), "clamp_mixed");

        // Direction change mid-run takes effect on the next step.
        ld_step(8'h00, 4'd0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0), "load_dir");
        step(1'b1, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0), ALL, "dir_up_carry");
        step(1'b1, 1'b0, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0), ALL, "dir_down_borrow");
        step(1'b1, 1'b0, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd8, 1'b0, 1'b0), ALL, "dir_down");
        step(1'b0, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd8, 1'b0, 1'b0), ALL, "enable_low_hold");

        // 00:12.3 -> 00:12.4 (lap captured on this step when the lap feature exists).
        ld_step(8'h00, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, pk(8'h00, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0), "load_12_3");
`ifdef TIMER_LAP_EN
        @(posedge tick);
        #1 lap = 1'b1;
`endif
        step(1'b1, 1'b1, 1'b0, pk(8'h00, 4'd1, 4'd2, 4'd4, 1'b0, 1'b0), ALL, "count_12_4");
`ifdef TIMER_LAP_EN
        @(posedge tick);
        #2 lap = 1'b0;
`endif
        drain();
`ifdef TIMER_LAP_EN
        check("lap_capture", {lap_min, lap_sec_msd, lap_sec_lsd, lap_tenth, lap_valid, 1'b0},
              pk(8'h00, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0), ALL);
`endif

        // Asynchronous clear between edges while counting.
        @(negedge tick);
        enable = 1'b1;
        @(posedge tick);
        #3 clr = 1'b1;
        #1 check("clr_async", obs, '0, ALL);
        @(posedge tick);
        #1 check("clr_held", obs, '0, ALL);
`ifdef TIMER_LAP_EN
        check("lap_cleared", {lap_min, lap_sec_msd, lap_sec_lsd, lap_tenth, lap_valid, 1'b0}, '0, ALL);
`endif
        @(negedge tick);
        clr    = 1'b0;
        enable = 1'b0;
        step(1'b1, 1'b1, 1'b0, pk(8'h00, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0), ALL, "first_after_clr");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
